mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage of the 8-bit processor; sits between the EX/MEM boundary and write-back.
- Decodes the memory op from EX and drives the 256x8 data memory port (async read, sync write).
- Owns the stack pointer for PUSH/POP and registers the MEM/WB pipeline bundle.
- Exports a same-cycle forwarding value for the hazard unit.

Parameters:
- DATA_W, 8, datapath width
- ADDR_W, 8, memory address width
- RA_W, 2, register-file index width
- SP_RESET, 8'hFF, stack pointer value after reset (stack grows downward)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold stage; no architectural update
- flush  in  1  kill incoming instruction
- ex_valid  in  1  EX/MEM slot holds a real instruction
- ex_op  in  3  0 NONE, 1 LDD, 2 STD, 3 LDI, 4 STI, 5 PUSH, 6 POP, 7 reserved (treated as NONE)
- ex_addr  in  ADDR_W  effective address for LDD/STD/LDI/STI
- ex_wdata  in  DATA_W  store/push data
- ex_alu  in  DATA_W  ALU result, passed through for NONE
- ex_rd  in  RA_W  destination register
- ex_reg_we  in  1  instruction writes a register
- dm_wen  out  1  data-memory write enable
- dm_ren  out  1  data-memory read enable
- dm_addr  out  ADDR_W  data-memory address
- dm_wdata  out  DATA_W  data-memory write data
- dm_rdata  in  DATA_W  data-memory read data (combinational)
- fwd_data  out  DATA_W  value this stage will write back (for forwarding)
- wb_valid  out  1  MEM/WB slot valid
- wb_rd  out  RA_W  MEM/WB destination register
- wb_we  out  1  MEM/WB register write enable
- wb_data  out  DATA_W  MEM/WB write-back data
- sp  out  ADDR_W  current stack pointer
- stack_err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (async, rst=1): sp=SP_RESET; stack_err=0; wb_valid=0, wb_we=0, wb_rd=0, wb_data=0. dm_* outputs follow the combinational rules below with go=0.
- go = ex_valid & ~stall & ~flush. All dm_wen/dm_ren/dm_addr/dm_wdata/fwd_data are combinational in the same cycle.
- LDD/LDI: dm_ren=1, dm_addr=ex_addr, fwd_data=dm_rdata.
- STD/STI: dm_wen=go, dm_addr=ex_addr, dm_wdata=ex_wdata.
- PUSH: dm_wen=go, dm_addr=sp, dm_wdata=ex_wdata; on the edge sp<=sp-1 (mod 256).
- POP: dm_ren=1, dm_addr=sp+1 (mod 256), fwd_data=dm_rdata; on the edge sp<=sp+1.
- NONE: dm_wen=0, dm_ren=0, dm_addr=0, dm_wdata=0, fwd_data=ex_alu.
- dm_wen is never asserted unless go=1. dm_ren may be asserted under stall (a read is harmless).
- stack_err: set on a PUSH with go and sp==0 (wraps to FF), or a POP with go and sp==SP_RESET (wraps). Cleared only by reset. The operation still completes with wrap-around.
- MEM/WB register, rising edge:
  - stall=1 and flush=0: all wb_* hold; sp holds.
  - flush=1 (wins over stall): wb_valid<=0, wb_we<=0, wb_rd/wb_data hold; no memory write; sp unchanged.
  - otherwise: wb_valid<=ex_valid, wb_we<=ex_valid&ex_reg_we, wb_rd<=ex_rd, wb_data<=fwd_data.
- Latency: memory effect lands in the same cycle; write-back data is valid 1 cycle later. Throughput is 1 op/cycle; back-to-back PUSH/POP must use the updated sp with no bubble.
- Reset asserted mid-operation: a pending write in that cycle is dropped (dm_wen forced 0 while rst=1).

Decomposition:
- Shared package mem_pkg: op encodings (MOP_NONE..MOP_POP), DATA_W/ADDR_W defaults, SP_RESET.
- Sub-module stack_ptr (sp register, next-sp, wrap, stack_err). Decode and MEM/WB register stay in mem_stage.

Test Plan:
- Reset, then STD addr 8'h10 data 8'hA5, then LDD 8'h10 rd=1 -> dm_wen high 1 cycle; next cycle after the load, wb_data=A5, wb_rd=1, wb_we=1.
- PUSH 8'h11, PUSH 8'h22, POP, POP back-to-back -> writes to FF, FE; sp goes FF→FE→FD→FE→FF; pops return 22 then 11; stack_err=0.
- POP right after reset -> reads addr 8'h00, sp=00, stack_err=1 and stays 1 through later pushes until rst.
- STD 8'h20 with stall=1 for 3 cycles -> dm_wen=0, wb_* and sp unchanged; write happens on the cycle stall drops.
- PUSH with flush=1 and stall=1 -> no write, sp unchanged, wb_valid=0 next cycle.
- NONE with ex_alu=8'h3C, reg_we=1 -> fwd_data=3C same cycle; wb_data=3C next cycle. Assert rst mid-cycle -> all wb_* 0 immediately, sp=FF.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: widths, stack reset value
// and the memory-op encoding carried from EX.
package mem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int RA_W   = 2;

  localparam logic [ADDR_W-1:0] SP_RESET = 8'hFF;

  typedef enum logic [2:0] {
    MOP_NONE = 3'd0,
    MOP_LDD  = 3'd1,
    MOP_STD  = 3'd2,
    MOP_LDI  = 3'd3,
    MOP_STI  = 3'd4,
    MOP_PUSH = 3'd5,
    MOP_POP  = 3'd6,
    MOP_RSVD = 3'd7
  } mem_op_e;

endpackage

// File: rtl/mem_stack_ptr.sv
// Downward-growing stack pointer with wrap-around and a sticky overflow/underflow flag.
// push/pop arrive already qualified, so the stage must only assert them for an instruction that really executes.
module stack_ptr
  import mem_pkg::*;
#(
  parameter int                ADDR_W   = mem_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] SP_RESET = mem_pkg::SP_RESET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              err_q, err_d;

  // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    if (push) begin
      sp_d = sp_q - ADDR_W'(1);
      if (sp_q == '0) err_d = 1'b1;
    end else if (pop) begin
      sp_d = sp_q + ADDR_W'(1);
      if (sp_q == SP_RESET) err_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= SP_RESET;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign sp        = sp_q;
  assign stack_err = err_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: decodes the EX memory op, drives the data-memory port,
// owns the stack pointer and registers the MEM/WB bundle.
module mem_stage
  import mem_pkg::*;
#(
  parameter int                DATA_W   = mem_pkg::DATA_W,
  parameter int                ADDR_W   = mem_pkg::ADDR_W,
  parameter int                RA_W     = mem_pkg::RA_W,
  parameter logic [ADDR_W-1:0] SP_RESET = mem_pkg::SP_RESET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [2:0]        ex_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              ex_reg_we,
  output logic              dm_wen,
  output logic              dm_ren,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_rd,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  logic go, wr_op, push_op, pop_op;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  assign go = ex_valid & ~stall & ~flush;

  always_comb begin
    wr_op    = 1'b0;
    push_op  = 1'b0;
    pop_op   = 1'b0;
    dm_ren   = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    fwd_data = ex_alu;
    case (mem_op_e'(ex_op))
      MOP_LDD, MOP_LDI: begin
        dm_ren   = 1'b1;
        dm_addr  = ex_addr;
        fwd_data = dm_rdata;
      end
      MOP_STD, MOP_STI: begin
        wr_op    = 1'b1;
        dm_addr  = ex_addr;
        dm_wdata = ex_wdata;
      end
      MOP_PUSH: begin
        wr_op    = 1'b1;
        push_op  = 1'b1;
        dm_addr  = sp;
        dm_wdata = ex_wdata;
      end
      MOP_POP: begin
        pop_op   = 1'b1;
        dm_ren   = 1'b1;
        dm_addr  = sp + ADDR_W'(1);
        fwd_data = dm_rdata;
      end
      default: ;
    endcase
  end

  // A write in the same cycle as reset assertion is dropped, even though go may be high.
  assign dm_wen = wr_op & go & ~rst;

  stack_ptr #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_stack_ptr (
    .clk       (clk),
    .rst       (rst),
    .push      (push_op & go),
    .pop       (pop_op & go),
    .sp        (sp),
    .stack_err (stack_err)
  );

  // Flush beats stall; a flushed slot keeps its stale rd/data but never writes back.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (flush) begin
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
    end else if (!stall) begin
      wb_valid_d = ex_valid;
      wb_we_d    = ex_valid & ex_reg_we;
      wb_rd_d    = ex_rd;
      wb_data_d  = fwd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: a behavioural model predicts memory
// port activity each cycle and queues the expected MEM/WB state for a separate monitor.
module tb_mem_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, flush, ex_valid, ex_reg_we;
  logic [2:0] ex_op;
  logic [7:0] ex_addr, ex_wdata, ex_alu;
  logic [1:0] ex_rd;
  logic       dm_wen, dm_ren;
  logic [7:0] dm_addr, dm_wdata, dm_rdata, fwd_data;
  logic       wb_valid, wb_we;
  logic [1:0] wb_rd;
  logic [7:0] wb_data, sp;
  logic       stack_err;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_op     (ex_op),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_alu    (ex_alu),
    .ex_rd     (ex_rd),
    .ex_reg_we (ex_reg_we),
    .dm_wen    (dm_wen),
    .dm_ren    (dm_ren),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .fwd_data  (fwd_data),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_we     (wb_we),
    .wb_data   (wb_data),
    .sp        (sp),
    .stack_err (stack_err)
  );

  // Data memory attached to the port: async read, sync write.
  logic [7:0] mem [256];
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) if (dm_wen) mem[dm_addr] <= dm_wdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural memory image, stack and MEM/WB slot.
  typedef struct {
    logic       valid;
    logic       we;
    logic [1:0] rd;
    logic [7:0] data;
    logic       chk_data;
    logic [7:0] sp;
    logic       err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_mem [256];
  logic [7:0] m_sp;
  logic       m_err, m_valid, m_we, m_chk;
  logic [1:0] m_rd;
  logic [7:0] m_data;

  task automatic model_reset();
    m_sp = 8'hFF; m_err = 1'b0;
    m_valid = 1'b0; m_we = 1'b0; m_rd = 2'd0; m_data = 8'h00; m_chk = 1'b1;
  endtask

  task automatic set_idle(input logic hold);
    ex_valid = 1'b0; ex_op = 3'd0; ex_addr = 8'h00; ex_wdata = 8'h00;
    ex_alu = 8'h00; ex_rd = 2'd0; ex_reg_we = 1'b0; stall = hold; flush = 1'b0;
  endtask

  // One instruction slot: starts and ends on a falling edge.
  task automatic apply(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] alu, input logic [1:0] rd,
                       input logic rwe, input logic st, input logic fl);
    logic       go, e_wen, e_ren, is_ld, is_st, is_push, is_pop;
    logic [7:0] e_addr, e_fwd;
    exp_t       e;
    ex_valid = v; ex_op = op; ex_addr = a; ex_wdata = wd; ex_alu = alu;
    ex_rd = rd; ex_reg_we = rwe; stall = st; flush = fl;
    #1;
    go      = v && !st && !fl;
    is_ld   = (op == 3'd1) || (op == 3'd3);
    is_st   = (op == 3'd2) || (op == 3'd4);
    is_push = (op == 3'd5);
    is_pop  = (op == 3'd6);
    e_wen = (is_st || is_push) && go;
    e_ren = is_ld || is_pop;
    e_addr = 8'h00;
    e_fwd  = alu;
    if (is_ld || is_st) e_addr = a;
    if (is_push) e_addr = m_sp;
    if (is_pop) e_addr = m_sp + 8'd1;
    if (e_ren) e_fwd = m_mem[e_addr];

    check("dm_wen", {7'd0, dm_wen}, {7'd0, e_wen});
    if (v) check("dm_ren", {7'd0, dm_ren}, {7'd0, e_ren});
    check("dm_addr", dm_addr, e_addr);
    if (is_st || is_push) check("dm_wdata", dm_wdata, wd);
    else if (!e_ren) check("dm_wdata", dm_wdata, 8'h00);
    check("fwd_data", fwd_data, e_fwd);

    if (go) begin
      if (is_st) m_mem[a] = wd;
      if (is_push) begin
        m_mem[m_sp] = wd;
        if (m_sp == 8'h00) m_err = 1'b1;
        m_sp = m_sp - 8'd1;
      end
      if (is_pop) begin
        if (m_sp == 8'hFF) m_err = 1'b1;
        m_sp = m_sp + 8'd1;
      end
    end
    if (fl) begin
      m_valid = 1'b0; m_we = 1'b0;
    end else if (!st) begin
      m_valid = v; m_we = v && rwe; m_rd = rd; m_data = e_fwd;
      m_chk = !(is_st || is_push);
    end
    e = '{valid: m_valid, we: m_we, rd: m_rd, data: m_data, chk_data: m_chk, sp: m_sp, err: m_err};
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: each queued entry describes the state right after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("wb_valid", {7'd0, wb_valid}, {7'd0, e.valid});
        check("wb_we", {7'd0, wb_we}, {7'd0, e.we});
        check("wb_rd", {6'd0, wb_rd}, {6'd0, e.rd});
        if (e.chk_data) check("wb_data", wb_data, e.data);
        check("sp", sp, e.sp);
        check("stack_err", {7'd0, stack_err}, {7'd0, e.err});
      end
    end
  end

  task automatic drain();
    set_idle(1'b1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    check("queue_drained", {7'd0, q.size() == 0}, 8'd1);
    @(negedge clk);
  endtask

  // Reset pulsed between edges while a store is being presented.
  task automatic mid_reset();
    drain();
    ex_valid = 1'b1; ex_op = 3'd2; ex_addr = 8'h33; ex_wdata = 8'hEE;
    ex_reg_we = 1'b0; stall = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_dm_wen", {7'd0, dm_wen}, 8'd0);
    check("rst_wb_valid", {7'd0, wb_valid}, 8'd0);
    check("rst_wb_we", {7'd0, wb_we}, 8'd0);
    check("rst_wb_rd", {6'd0, wb_rd}, 8'd0);
    check("rst_wb_data", wb_data, 8'h00);
    check("rst_sp", sp, 8'hFF);
    check("rst_stack_err", {7'd0, stack_err}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i) ^ 8'h5A;
      m_mem[i] = 8'(i) ^ 8'h5A;
    end
    model_reset();
    set_idle(1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sp", sp, 8'hFF);
    check("reset_stack_err", {7'd0, stack_err}, 8'd0);
    check("reset_wb_valid", {7'd0, wb_valid}, 8'd0);
    check("reset_wb_data", wb_data, 8'h00);
    check("reset_dm_wen", {7'd0, dm_wen}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Store then load back.
    apply(1, 3'd2, 8'h10, 8'hA5, 8'h00, 2'd0, 0, 0, 0);
    apply(1, 3'd1, 8'h10, 8'h00, 8'h00, 2'd1, 1, 0, 0);
    // Back-to-back stack traffic.
    apply(1, 3'd5, 8'h00, 8'h11, 8'h00, 2'd0, 0, 0, 0);
    apply(1, 3'd5, 8'h00, 8'h22, 8'h00, 2'd0, 0, 0, 0);
    apply(1, 3'd6, 8'h00, 8'h00, 8'h00, 2'd2, 1, 0, 0);
    apply(1, 3'd6, 8'h00, 8'h00, 8'h00, 2'd3, 1, 0, 0);
    // Underflow right after reset; flag stays through later pushes.
    mid_reset();
    apply(1, 3'd6, 8'h00, 8'h00, 8'h00, 2'd1, 1, 0, 0);
    apply(1, 3'd5, 8'h00, 8'h44, 8'h00, 2'd0, 0, 0, 0);
    apply(1, 3'd5, 8'h00, 8'h55, 8'h00, 2'd0, 0, 0, 0);
    // Stalled store lands only when the stall drops.
    mid_reset();
    for (int i = 0; i < 3; i++) apply(1, 3'd2, 8'h20, 8'h5C, 8'h00, 2'd0, 0, 1, 0);
    apply(1, 3'd2, 8'h20, 8'h5C, 8'h00, 2'd0, 0, 0, 0);
    apply(1, 3'd1, 8'h20, 8'h00, 8'h00, 2'd2, 1, 0, 0);
    // Flush wins over stall.
    apply(1, 3'd5, 8'h00, 8'h77, 8'h00, 2'd0, 0, 1, 1);
    // ALU pass-through, then reset mid-cycle.
    apply(1, 3'd0, 8'h00, 8'h00, 8'h3C, 2'd3, 1, 0, 0);
    apply(1, 3'd7, 8'h12, 8'h34, 8'hC3, 2'd2, 1, 0, 0);
    mid_reset();

    for (int n = 0; n < 600; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 1) == 1) ? (8'hF0 | 8'($urandom_range(0, 15)))
                                      : 8'($urandom_range(0, 15));
      apply($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), a,
            8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0);
      if (n == 300) mid_reset();
    end

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
